uart_tx_framer: RTL and testbench

UART_TX_FRAMER -- requirements
Module: uart_tx_framer

---
 rtl/uart_tx_framer.sv | 147 ++++++++++++++
 tb/tb_uart_tx_framer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_framer.sv
// UART transmit framer: 8N1 framing with optional even/odd parity bit.
// Bit timing comes from a cycle counter used as a clock enable; there are no derived clocks.
module uart_tx_framer #(
  parameter int clk_freq    = 1000000,
  parameter int baud_rate   = 9600,
  parameter int parity_mode = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       newd,
  input  logic [7:0] tx_data,
  output logic       ready,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic [2:0] o_dbg_state
);

  localparam int CPB = clk_freq / baud_rate;
  localparam int CW  = (CPB > 2) ? $clog2(CPB) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);

  generate
    if (CPB < 2) begin : g_cpb_check
      $error("uart_tx_framer: clk_freq/baud_rate must be at least 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_idx;
  logic [7:0]      r_shift;
  logic            r_par;
  logic            r_tx;
  logic            r_done;
  logic            w_tx_next;
  logic            w_done_next;
  logic            w_accept;
  logic            w_bit_end;
  logic            w_par_calc;

  // Handshake: a byte is taken on any cycle where newd && ready; ready is high only in IDLE,
  // and a newd seen while ready is low is dropped, never queued.
  assign w_bit_end  = (r_cnt == CNT_LAST);
  assign w_par_calc = (^tx_data) ^ (parity_mode == 2);

  always_comb begin
    w_state_next = r_state;
    w_tx_next    = r_tx;
    w_done_next  = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        w_tx_next = 1'b1;
        if (newd) begin
          w_accept     = 1'b1;
          w_state_next = START;
          w_tx_next    = 1'b0;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_state_next = DATA;
          w_tx_next    = r_shift[0];
        end
      end
      DATA: begin
        if (w_bit_end) begin
          if (r_idx == 3'd7) begin
            if (parity_mode != 0) begin
              w_state_next = PARITY;
              w_tx_next    = r_par;
            end else begin
              w_state_next = STOP;
              w_tx_next    = 1'b1;
            end
          end else begin
            // r_shift[0] is the bit on the line now; the next one sits just above it
            w_tx_next = r_shift[1];
          end
        end
      end
      PARITY: begin
        if (w_bit_end) begin
          w_state_next = STOP;
          w_tx_next    = 1'b1;
        end
      end
      STOP: begin
        if (w_bit_end) begin
          w_state_next = IDLE;
          w_tx_next    = 1'b1;
          w_done_next  = 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_tx_next    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
      r_cnt   <= '0;
      r_idx   <= 3'd0;
      r_shift <= 8'd0;
      r_par   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_tx    <= w_tx_next;
      r_done  <= w_done_next;
      if (r_state == IDLE || w_bit_end) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_accept) begin
        r_shift <= tx_data;
        r_idx   <= 3'd0;
        r_par   <= w_par_calc;
      end else if (r_state == DATA && w_bit_end) begin
        r_shift <= {1'b0, r_shift[7:1]};
        r_idx   <= r_idx + 3'd1;
      end
    end
  end

  assign ready       = (r_state == IDLE);
  assign busy        = ~ready;
  assign tx          = r_tx;
  assign done        = r_done;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Bench for uart_tx_framer: three instances (no/even/odd parity) checked every cycle against
// a frame-level line model, plus a mid-bit sampling receiver with literal expectations.
module tb_uart_tx_framer;

  localparam int CLK_FREQ = 1000000;
  localparam int BAUD     = 9600;
  localparam int CPB      = CLK_FREQ / BAUD;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst_w  = 3'b111;
  logic [2:0] newd_w = 3'b000;
  logic [7:0] data_w [3];
  logic [2:0] tx_w, ready_w, busy_w, done_w;
  logic [2:0] dbg_w  [3];

  int cyc    = 0;
  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    uart_tx_framer #(
      .clk_freq   (CLK_FREQ),
      .baud_rate  (BAUD),
      .parity_mode(g)
    ) u_dut (
      .clk        (clk),
      .rst        (rst_w[g]),
      .newd       (newd_w[g]),
      .tx_data    (data_w[g]),
      .ready      (ready_w[g]),
      .tx         (tx_w[g]),
      .busy       (busy_w[g]),
      .done       (done_w[g]),
      .o_dbg_state(dbg_w[g])
    );
  end

  // ---------------- line model ----------------
  // m_since = cycles elapsed since acceptance (0 = idle); the frame is a bit list, each bit CPB long.
  int         m_since [3] = '{0, 0, 0};
  logic       m_done  [3] = '{1'b0, 1'b0, 1'b0};
  logic [10:0] m_frame [3];

  function automatic logic [10:0] make_frame(input logic [7:0] b, input int mode);
    logic [10:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = b;
    if (mode == 1) f[9] = ^b;
    if (mode == 2) f[9] = ~(^b);
    return f;
  endfunction

  function automatic int frame_len(input int mode);
    return ((mode == 0) ? 10 : 11) * CPB;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int d = 0; d < 3; d++) begin
      if (rst_w[d]) begin
        m_since[d] <= 0;
        m_done[d]  <= 1'b0;
      end else if (m_since[d] == 0) begin
        m_done[d] <= 1'b0;
        if (newd_w[d]) begin
          m_frame[d] <= make_frame(data_w[d], d);
          m_since[d] <= 1;
        end
      end else if (m_since[d] == frame_len(d)) begin
        m_since[d] <= 0;
        m_done[d]  <= 1'b1;
      end else begin
        m_since[d] <= m_since[d] + 1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 3; d++) begin
        logic [3:0] exp_v, act_v;
        if (m_since[d] == 0) exp_v = {1'b1, 1'b1, 1'b0, m_done[d]};
        else                 exp_v = {m_frame[d][(m_since[d] - 1) / CPB], 1'b0, 1'b1, 1'b0};
        act_v = {tx_w[d], ready_w[d], busy_w[d], done_w[d]};
        checks++;
        if (act_v !== exp_v) begin
          errors++;
          $display("FAIL line_dut%0d cyc=%0d {tx,ready,busy,done} got %b expected %b",
                   d, cyc, act_v, exp_v);
        end
      end
    end
  end

  // ---------------- driver / receiver tasks ----------------
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // One-cycle newd pulse; a = cycle number of the acceptance cycle.
  task automatic accept(input int d, input logic [7:0] b, output int a);
    @(posedge clk); #1;
    newd_w[d] = 1'b1;
    data_w[d] = b;
    @(posedge clk); #1;
    newd_w[d] = 1'b0;
    a = cyc - 1;
  endtask

  // Reference receiver: finds the start edge, samples each bit mid-period, notes the done cycle.
  task automatic rx_frame(input int d, input int nb, output int s_cyc,
                          output logic [10:0] bits, output int d_cyc);
    int off;
    s_cyc = -1;
    d_cyc = -1;
    bits  = '1;
    for (int i = 0; i < 2000 && s_cyc < 0; i++) begin
      @(negedge clk);
      if (tx_w[d] === 1'b0) s_cyc = cyc;
    end
    if (s_cyc >= 0) begin
      for (int t = 1; t <= nb * CPB; t++) begin
        @(negedge clk);
        off = cyc - s_cyc;
        if ((off % CPB) == CPB / 2 && (off / CPB) < nb) bits[off / CPB] = tx_w[d];
        if (done_w[d] === 1'b1 && d_cyc < 0) d_cyc = cyc;
      end
    end
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int a, s, dn, s2, dn2;
    logic [10:0] bits, bits2;
    bit seen_low, seen_done;

    data_w[0] = 8'h5A; data_w[1] = 8'h5A; data_w[2] = 8'h5A;
    newd_w    = 3'b111;

    // reset with newd held high
    @(posedge clk); #1;
    chk_en = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_tx",    tx_w[0],    1);
      check("rst_ready", ready_w[0], 1);
      check("rst_busy",  busy_w[0],  0);
      check("rst_done",  done_w[0],  0);
    end
    @(posedge clk); #1;
    rst_w  = 3'b000;
    newd_w = 3'b000;
    repeat (20) @(negedge clk);
    check("post_rst_ready_all", ready_w, 7);
    check("post_rst_tx_all",    tx_w,    7);

    // basic 0x55 frame
    accept(0, 8'h55, a);
    rx_frame(0, 10, s, bits, dn);
    check("basic_start",  s - a, 1);
    check("basic_levels", bits[9:0], 10'h2AA);
    check("basic_done",   dn - a, 1041);
    repeat (5) @(posedge clk);

    // request ignored while busy
    accept(0, 8'hA3, a);
    fork
      rx_frame(0, 10, s, bits, dn);
      begin
        repeat (299) @(posedge clk);
        #1;
        newd_w[0] = 1'b1;
        data_w[0] = 8'hFF;
        @(negedge clk);
        check("ign_ready_low", ready_w[0], 0);
        @(posedge clk); #1;
        newd_w[0] = 1'b0;
      end
    join
    check("ign_byte", bits[8:1], 8'hA3);
    check("ign_stop", bits[9], 1);
    check("ign_done", dn - a, 1041);
    repeat (200) @(negedge clk);
    check("ign_no_second_frame", ready_w[0], 1);

    // back-to-back with newd held high
    @(posedge clk); #1;
    newd_w[0] = 1'b1;
    data_w[0] = 8'h00;
    @(posedge clk); #1;
    a = cyc - 1;
    data_w[0] = 8'hFF;
    rx_frame(0, 10, s, bits, dn);
    fork
      rx_frame(0, 10, s2, bits2, dn2);
      begin
        @(posedge clk); #1;
        newd_w[0] = 1'b0;
      end
    join
    check("b2b_first_start", s - a, 1);
    check("b2b_first_byte",  bits[8:1], 8'h00);
    check("b2b_first_done",  dn - a, 1041);
    check("b2b_gap",         s2 - dn, 1);
    check("b2b_second_byte", bits2[8:1], 8'hFF);
    check("b2b_second_stop", bits2[9], 1);
    check("b2b_second_done", dn2 - dn, 1041);
    repeat (5) @(posedge clk);

    // parity: even then odd
    accept(1, 8'h07, a);
    rx_frame(1, 11, s, bits, dn);
    check("even_byte",  bits[8:1], 8'h07);
    check("even_par",   bits[9], 1);
    check("even_stop",  bits[10], 1);
    check("even_done",  dn - a, 1145);
    accept(2, 8'h07, a);
    rx_frame(2, 11, s, bits, dn);
    check("odd_byte",   bits[8:1], 8'h07);
    check("odd_par",    bits[9], 0);
    check("odd_stop",   bits[10], 1);
    check("odd_done",   dn - a, 1145);

    // abort during data bit 3 of 0xC3
    accept(0, 8'hC3, a);
    repeat (450) @(posedge clk);
    #1;
    check("abort_pre_tx", tx_w[0], 0);
    rst_w[0] = 1'b1;
    @(posedge clk); #1;
    rst_w[0] = 1'b0;
    @(negedge clk);
    check("abort_tx",    tx_w[0],    1);
    check("abort_ready", ready_w[0], 1);
    check("abort_done",  done_w[0],  0);
    seen_low  = 1'b0;
    seen_done = 1'b0;
    repeat (1100) begin
      @(negedge clk);
      if (tx_w[0] !== 1'b1)   seen_low  = 1'b1;
      if (done_w[0] !== 1'b0) seen_done = 1'b1;
    end
    check("abort_no_resume", seen_low,  0);
    check("abort_no_done",   seen_done, 0);
    accept(0, 8'h3C, a);
    rx_frame(0, 10, s, bits, dn);
    check("after_abort_start", s - a, 1);
    check("after_abort_byte",  bits[8:1], 8'h3C);
    check("after_abort_done",  dn - a, 1041);

    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: run did not complete, cyc=%0d", cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
